epsilon_bandit: RTL and testbench
=================================

EPSILON_BANDIT -- requirements
Module: epsilon_bandit

Interface
REQ-001 The module SHALL have parameter ACTION_WIDTH, default 8, meaning log2 of action count N = 2**ACTION_WIDTH.
REQ-002 The module SHALL have parameter VALUE_WIDTH, default 16, meaning signed action-value width.
REQ-003 The module SHALL have parameter REWARD_WIDTH, default 8, meaning signed reward width, legal range 2..VALUE_WIDTH.
REQ-004 The module SHALL have parameter ALPHA_SHIFT, default 3, meaning step size alpha = 2**-ALPHA_SHIFT.
REQ-005 The module SHALL have parameter EPSILON_SHIFT, default 4, meaning exploration probability of about 2**-EPSILON_SHIFT, where 0 disables exploration.
REQ-006 The module SHALL have parameter INIT_VALUE, default 0, meaning the signed value written to every table entry during CLEAR.
REQ-007 The module SHALL have parameter SEED, default 16'hace1, meaning the nonzero 16-bit LFSR reset state.
REQ-008 The module SHALL have parameter TAPS, default 16'hb400, meaning the maximal-length 16-bit Fibonacci LFSR tap mask.
REQ-009 The module SHALL have port clock, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-010 The module SHALL have port reset, input, 1 bit, meaning a synchronous, active-high reset.
REQ-011 The module SHALL have ports reward_valid (input, 1), reward_data (input, REWARD_WIDTH, signed) and reward_ready (output, 1), forming a valid/ready reward sink.
REQ-012 The module SHALL have ports action_valid (output, 1), action_data (output, ACTION_WIDTH) and action_ready (input, 1), forming a valid/ready action source.
REQ-013 The module SHALL have port action_explore, output, 1 bit, which is high with action_valid when the offered action was chosen by exploration.

Function
REQ-014 The module SHALL store an N x VALUE_WIDTH table in synchronous-read single-port RAM and use a 16-bit LFSR that advances every cycle it is out of reset.
REQ-015 The FSM SHALL have the states CLEAR, SCAN, ACTUATE and OBSERVE; the reset state is CLEAR.
REQ-016 In CLEAR, the module SHALL write INIT_VALUE to addresses 0..N-1, one per cycle, then enter SCAN; CLEAR lasts exactly N cycles.
REQ-017 On the first SCAN cycle, if EPSILON_SHIFT>0 and the LFSR bits [EPSILON_SHIFT-1:0] are all zero, the module SHALL latch LFSR[15:16-ACTION_WIDTH] as the action, set the explore flag, and enter ACTUATE on the next cycle.
REQ-018 Otherwise, SCAN SHALL read addresses 0..N-1 in order and compare each value one cycle later; SCAN lasts N+1 cycles, then the module enters ACTUATE.
REQ-019 The SCAN argmax SHALL be initialised to the entry at address 0 and replaced only when a later entry is strictly greater (signed), so ties resolve to the lowest index.
REQ-020 In ACTUATE, action_valid SHALL be 1 and action_data/action_explore SHALL be held stable until action_ready=1, then the module enters OBSERVE.
REQ-021 In OBSERVE, reward_ready SHALL be 1; on reward_valid=1 the module SHALL write the update to the chosen entry and enter SCAN.
REQ-022 The update SHALL be Q' = Q + ((sext(R) - Q) >>> ALPHA_SHIFT), with the difference computed at VALUE_WIDTH+1 bits, an arithmetic shift (rounding toward minus infinity), and the result truncated to VALUE_WIDTH bits; no overflow is possible.
REQ-023 The Q used in the update SHALL be the value latched at decision time, since the table is written only in OBSERVE.
REQ-024 Outside their states, action_valid and reward_ready SHALL be 0, and neither SHALL depend combinationally on its own handshake inputs.
REQ-025 reward_valid outside OBSERVE SHALL be ignored and no write shall occur; an action_ready held high before ACTUATE SHALL complete the handshake on the first ACTUATE cycle.

Reset
REQ-026 On reset=1, the module SHALL enter CLEAR and load the LFSR with SEED, and all outputs SHALL be 0 on the following cycle: action_valid, action_data, action_explore, reward_ready.
REQ-027 A reset asserted in any state, including mid-CLEAR and mid-SCAN, SHALL abort the operation and restart CLEAR from address 0, re-initialising the entire table.
REQ-028 The table contents SHALL be undefined only until CLEAR completes.

Verification
REQ-029 With ACTION_WIDTH=2, EPSILON_SHIFT=0, INIT_VALUE=0 and action_ready=1: release reset -> action_valid first high exactly 4+5 cycles later, with action_data=0 and action_explore=0.
REQ-030 With ACTION_WIDTH=2 and ALPHA_SHIFT=3: reward 64 on action 0 -> Q[0]=8 and the next action is 0; then reward -128 -> Q[0]=-9 and the next action is 1.
REQ-031 Backpressure: hold action_ready=0 for 10 cycles -> action_data stays stable, reward_ready=0 throughout, and a reward_valid pulse during ACTUATE causes no table change.
REQ-032 Reset asserted on SCAN cycle 2 -> outputs are 0 the next cycle, CLEAR runs N cycles, and previously learned values return to INIT_VALUE.
REQ-033 With EPSILON_SHIFT=2 over 4000 decisions: exploration fraction is within 0.20-0.30, explored actions match a reference LFSR model, and action_explore=1 exactly on those actions.
REQ-034 With VALUE_WIDTH=8, REWARD_WIDTH=8 and INIT_VALUE=127: reward -128 repeated -> Q decreases monotonically toward -128 with no wrap.

Source files
------------

// File: rtl/epsilon_bandit.sv
// Epsilon-greedy multi-armed bandit: a table of action values in single-port RAM,
// a greedy argmax scan or an LFSR-driven random pick, and an exponential-average update.
//   state    | meaning
//   CLEAR    | write INIT_VALUE to every table entry, one per cycle
//   SCAN     | explore check on first cycle, else sequential read + argmax
//   ACTUATE  | offer the chosen action until action_ready
//   OBSERVE  | wait for a reward, write the updated value back
module epsilon_bandit #(
  parameter int          ACTION_WIDTH  = 8,
  parameter int          VALUE_WIDTH   = 16,
  parameter int          REWARD_WIDTH  = 8,
  parameter int          ALPHA_SHIFT   = 3,
  parameter int          EPSILON_SHIFT = 4,
  parameter int          INIT_VALUE    = 0,
  parameter logic [15:0] SEED          = 16'hace1,
  parameter logic [15:0] TAPS          = 16'hb400
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    reward_valid,
  input  logic [REWARD_WIDTH-1:0] reward_data,
  output logic                    reward_ready,
  output logic                    action_valid,
  output logic [ACTION_WIDTH-1:0] action_data,
  input  logic                    action_ready,
  output logic                    action_explore
);

  localparam int                    N            = 2 ** ACTION_WIDTH;
  localparam logic [ACTION_WIDTH:0] CNT_N        = (ACTION_WIDTH+1)'(N);
  localparam logic [ACTION_WIDTH:0] CNT_ONE      = (ACTION_WIDTH+1)'(1);
  localparam logic [ACTION_WIDTH:0] CNT_CLR_LAST = CNT_N - CNT_ONE;
  localparam logic [15:0]           EPS_MASK     = 16'((32'd1 << EPSILON_SHIFT) - 32'd1);
  localparam logic [VALUE_WIDTH-1:0] INIT_W      = VALUE_WIDTH'(INIT_VALUE);

  typedef enum logic [1:0] {
    S_CLEAR   = 2'd0,
    S_SCAN    = 2'd1,
    S_ACTUATE = 2'd2,
    S_OBSERVE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ACTION_WIDTH:0]   cnt_q, cnt_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [ACTION_WIDTH-1:0] act_q, act_d;
  logic [ACTION_WIDTH-1:0] best_idx_q, best_idx_d;
  logic [VALUE_WIDTH-1:0]  best_val_q, best_val_d;
  logic                    explore_q, explore_d;
  logic                    action_valid_q, reward_ready_q;

  logic [VALUE_WIDTH-1:0]  table_q [N];
  logic [VALUE_WIDTH-1:0]  rd_data_q;
  logic                    ram_we, ram_re;
  logic [ACTION_WIDTH-1:0] ram_addr;
  logic [VALUE_WIDTH-1:0]  ram_wdata;

  logic                    explore_hit;
  logic [ACTION_WIDTH-1:0] explore_act, scan_idx;
  logic [VALUE_WIDTH-1:0]  q_old, q_new;
  logic signed [VALUE_WIDTH:0] rew_ext, q_ext, diff, step;

  assign explore_hit = (EPSILON_SHIFT > 0) && ((lfsr_q & EPS_MASK) == 16'd0);
  assign explore_act = lfsr_q[15 -: ACTION_WIDTH];
  assign scan_idx    = ACTION_WIDTH'(cnt_q - CNT_ONE);

  // An explored entry is read on the decision cycle and nothing reads the RAM again until
  // the write-back, so rd_data_q still holds its value in OBSERVE.
  assign q_old   = explore_q ? rd_data_q : best_val_q;
  assign rew_ext = $signed({{(VALUE_WIDTH+1-REWARD_WIDTH){reward_data[REWARD_WIDTH-1]}}, reward_data});
  assign q_ext   = $signed({q_old[VALUE_WIDTH-1], q_old});
  assign diff    = rew_ext - q_ext;
  assign step    = diff >>> ALPHA_SHIFT;
  assign q_new   = VALUE_WIDTH'(q_ext + step);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_d      = act_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    explore_d  = explore_q;
    lfsr_d     = {lfsr_q[14:0], ^(lfsr_q & TAPS)};
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = cnt_q[ACTION_WIDTH-1:0];
    ram_wdata  = INIT_W;
    case (state_q)
      S_CLEAR: begin
        ram_we = 1'b1;
        if (cnt_q == CNT_CLR_LAST) begin
          state_d = S_SCAN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_SCAN: begin
        if (cnt_q == '0 && explore_hit) begin
          act_d     = explore_act;
          explore_d = 1'b1;
          ram_re    = 1'b1;
          ram_addr  = explore_act;
          state_d   = S_ACTUATE;
        end else begin
          explore_d = 1'b0;
          if (cnt_q < CNT_N) ram_re = 1'b1;
          if (cnt_q == CNT_ONE) begin
            best_idx_d = '0;
            best_val_d = rd_data_q;
          end else if (cnt_q != '0 && $signed(rd_data_q) > $signed(best_val_q)) begin
            best_idx_d = scan_idx;
            best_val_d = rd_data_q;
          end
          if (cnt_q == CNT_N) begin
            act_d   = best_idx_d;
            cnt_d   = '0;
            state_d = S_ACTUATE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_ACTUATE: begin
        if (action_ready) state_d = S_OBSERVE;
      end
      S_OBSERVE: begin
        if (reward_valid) begin
          ram_we    = 1'b1;
          ram_addr  = act_q;
          ram_wdata = q_new;
          cnt_d     = '0;
          state_d   = S_SCAN;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_CLEAR;
      cnt_q          <= '0;
      lfsr_q         <= SEED;
      act_q          <= '0;
      best_idx_q     <= '0;
      best_val_q     <= '0;
      explore_q      <= 1'b0;
      action_valid_q <= 1'b0;
      reward_ready_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lfsr_q         <= lfsr_d;
      act_q          <= act_d;
      best_idx_q     <= best_idx_d;
      best_val_q     <= best_val_d;
      explore_q      <= explore_d;
      action_valid_q <= (state_d == S_ACTUATE);
      reward_ready_q <= (state_d == S_OBSERVE);
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we && !reset) table_q[ram_addr] <= ram_wdata;
    if (ram_re) rd_data_q <= table_q[ram_addr];
  end

  assign action_valid   = action_valid_q;
  assign action_data    = act_q;
  assign action_explore = explore_q;
  assign reward_ready   = reward_ready_q;

endmodule

// File: tb/tb_epsilon_bandit.sv
// Bench for epsilon_bandit: a greedy instance (A) and an exploring 8-bit instance (B),
// each with a value-table model and a queue of predicted decisions.
module tb_epsilon_bandit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic       a_reset = 1'b1, a_reward_valid = 1'b0, a_action_ready = 1'b1;
  logic [7:0] a_reward_data = '0;
  logic       a_reward_ready, a_action_valid, a_action_explore;
  logic [1:0] a_action_data;

  logic       b_reset = 1'b1, b_reward_valid = 1'b0, b_action_ready = 1'b1;
  logic [7:0] b_reward_data = '0;
  logic       b_reward_ready, b_action_valid, b_action_explore;
  logic [1:0] b_action_data;

  epsilon_bandit #(.ACTION_WIDTH(2), .VALUE_WIDTH(16), .REWARD_WIDTH(8), .ALPHA_SHIFT(3),
                   .EPSILON_SHIFT(0), .INIT_VALUE(0)) dut_a (
    .clock(clock), .reset(a_reset),
    .reward_valid(a_reward_valid), .reward_data(a_reward_data), .reward_ready(a_reward_ready),
    .action_valid(a_action_valid), .action_data(a_action_data), .action_ready(a_action_ready),
    .action_explore(a_action_explore));

  epsilon_bandit #(.ACTION_WIDTH(2), .VALUE_WIDTH(8), .REWARD_WIDTH(8), .ALPHA_SHIFT(3),
                   .EPSILON_SHIFT(2), .INIT_VALUE(127)) dut_b (
    .clock(clock), .reset(b_reset),
    .reward_valid(b_reward_valid), .reward_data(b_reward_data), .reward_ready(b_reward_ready),
    .action_valid(b_action_valid), .action_data(b_action_data), .action_ready(b_action_ready),
    .action_explore(b_action_explore));

  typedef struct { int act; bit explore; } exp_t;
  exp_t sb_a[$];
  exp_t sb_b[$];
  int   qa[4];
  int   qb[4];
  int   cur_a, cur_b, lat;

  // Reference LFSR for B: x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB.
  logic [15:0] lfsr_m;
  always @(posedge clock)
    if (b_reset) lfsr_m <= 16'hace1;
    else lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};

  function automatic int best_of(input int q[4]);
    int b = 0;
    for (int i = 1; i < 4; i++) if (q[i] > q[b]) b = i;
    return b;
  endfunction

  function automatic int learn(input int q, input int r);
    return q + ((r - q) >>> 3);
  endfunction

  task automatic push_a();
    exp_t e;
    e.act = best_of(qa);
    e.explore = 1'b0;
    sb_a.push_back(e);
  endtask

  task automatic b_predict();
    exp_t e;
    if (lfsr_m[1:0] == 2'b00) begin
      e.act = int'(lfsr_m[15:14]);
      e.explore = 1'b1;
    end else begin
      e.act = best_of(qb);
      e.explore = 1'b0;
    end
    sb_b.push_back(e);
  endtask

  task automatic a_take_action(output int act, output int latency);
    exp_t e;
    bit got = 1'b0;
    act = 0;
    latency = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clock);
      if (a_action_valid) begin got = 1'b1; latency = k; end
    end
    checks++;
    if (!got || sb_a.size() == 0) begin
      errors++;
      $display("FAIL a_action_wait: action_valid=%0b queued=%0d, required valid with a queued prediction",
               a_action_valid, sb_a.size());
      return;
    end
    e = sb_a.pop_front();
    checks++;
    if (int'(a_action_data) !== e.act) begin
      errors++;
      $display("FAIL a_action_data: got %0d, required %0d", a_action_data, e.act);
    end
    checks++;
    if (a_action_explore !== e.explore) begin
      errors++;
      $display("FAIL a_action_explore: got %0b, required %0b", a_action_explore, e.explore);
    end
    act = e.act;
  endtask

  task automatic a_give_reward(input int r, input int act);
    bit rdy = 1'b0;
    for (int k = 0; k < 8 && !rdy; k++) begin
      if (a_reward_ready) rdy = 1'b1;
      else @(negedge clock);
    end
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL a_reward_wait: reward_ready=0 after 8 cycles, required 1");
    end
    a_reward_valid = 1'b1;
    a_reward_data  = 8'(r);
    @(negedge clock);
    a_reward_valid = 1'b0;
    qa[act] = learn(qa[act], r);
    push_a();
  endtask

  task automatic b_take_action(output int act, output int ex);
    exp_t e;
    bit got = 1'b0;
    act = 0;
    ex = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clock);
      if (b_action_valid) got = 1'b1;
    end
    checks++;
    if (!got || sb_b.size() == 0) begin
      errors++;
      $display("FAIL b_action_wait: action_valid=%0b queued=%0d, required valid with a queued prediction",
               b_action_valid, sb_b.size());
      return;
    end
    e = sb_b.pop_front();
    checks++;
    if (int'(b_action_data) !== e.act || b_action_explore !== e.explore) begin
      errors++;
      $display("FAIL b_decision: got action %0d explore %0b, required action %0d explore %0b",
               b_action_data, b_action_explore, e.act, e.explore);
    end
    act = e.act;
    ex = int'(b_action_explore);
  endtask

  task automatic b_give_reward(input int r, input int act);
    bit rdy = 1'b0;
    for (int k = 0; k < 8 && !rdy; k++) begin
      if (b_reward_ready) rdy = 1'b1;
      else @(negedge clock);
    end
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL b_reward_wait: reward_ready=0 after 8 cycles, required 1");
    end
    b_reward_valid = 1'b1;
    b_reward_data  = 8'(r);
    @(negedge clock);
    b_reward_valid = 1'b0;
    qb[act] = learn(qb[act], r);
    b_predict();
  endtask

  task automatic test_reset();
    a_reset = 1'b1;
    a_action_ready = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (a_action_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", a_action_valid); end
    checks++;
    if (a_action_data !== 2'd0) begin errors++; $display("FAIL reset_data: got %0d, required 0", a_action_data); end
    checks++;
    if (a_action_explore !== 1'b0) begin errors++; $display("FAIL reset_explore: got %0b, required 0", a_action_explore); end
    checks++;
    if (a_reward_ready !== 1'b0) begin errors++; $display("FAIL reset_reward_ready: got %0b, required 0", a_reward_ready); end
    qa = '{0, 0, 0, 0};
    sb_a.delete();
    push_a();
    a_reset = 1'b0;
    a_take_action(cur_a, lat);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL first_latency: got %0d cycles, required 9", lat); end
  endtask

  task automatic test_learning();
    int v;
    a_give_reward(64, cur_a);
    v = $signed(dut_a.table_q[0]);
    checks++;
    if (v !== 8) begin errors++; $display("FAIL learn_q0_first: got %0d, required 8", v); end
    a_take_action(cur_a, lat);
    @(negedge clock);
    checks++;
    if (a_action_valid !== 1'b0 || a_reward_ready !== 1'b1) begin
      errors++;
      $display("FAIL early_ready_handshake: valid %0b reward_ready %0b, required 0 and 1",
               a_action_valid, a_reward_ready);
    end
    a_give_reward(-128, cur_a);
    v = $signed(dut_a.table_q[0]);
    checks++;
    if (v !== -9) begin errors++; $display("FAIL learn_q0_second: got %0d, required -9", v); end
    a_take_action(cur_a, lat);
  endtask

  task automatic test_backpressure();
    int v;
    a_give_reward(20, cur_a);
    a_action_ready = 1'b0;
    a_take_action(cur_a, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if (a_action_valid !== 1'b1 || int'(a_action_data) !== cur_a || a_reward_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid %0b data %0d reward_ready %0b, required 1 %0d 0",
                 i, a_action_valid, a_action_data, a_reward_ready, cur_a);
      end
      if (i == 3) begin a_reward_valid = 1'b1; a_reward_data = 8'd100; end
      if (i == 4) a_reward_valid = 1'b0;
    end
    for (int j = 0; j < 4; j++) begin
      v = $signed(dut_a.table_q[j]);
      checks++;
      if (v !== qa[j]) begin errors++; $display("FAIL stray_reward_q%0d: got %0d, required %0d", j, v, qa[j]); end
    end
    a_action_ready = 1'b1;
    a_give_reward(-50, cur_a);
    a_take_action(cur_a, lat);
    a_give_reward(10, cur_a);
  endtask

  task automatic test_reset_mid_scan();
    int v;
    @(negedge clock);
    @(negedge clock);
    a_reset = 1'b1;
    @(negedge clock);
    checks++;
    if (a_action_valid !== 1'b0 || a_action_data !== 2'd0 || a_action_explore !== 1'b0 || a_reward_ready !== 1'b0) begin
      errors++;
      $display("FAIL midscan_reset_outputs: valid %0b data %0d explore %0b ready %0b, required all 0",
               a_action_valid, a_action_data, a_action_explore, a_reward_ready);
    end
    a_reset = 1'b0;
    qa = '{0, 0, 0, 0};
    sb_a.delete();
    push_a();
    a_take_action(cur_a, lat);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL midscan_relatency: got %0d cycles, required 9", lat); end
    for (int j = 0; j < 4; j++) begin
      v = $signed(dut_a.table_q[j]);
      checks++;
      if (v !== 0) begin errors++; $display("FAIL midscan_clear_q%0d: got %0d, required 0", j, v); end
    end
  endtask

  task automatic test_saturation();
    int v, old, ex;
    b_reset = 1'b1;
    b_action_ready = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (b_action_valid !== 1'b0 || b_reward_ready !== 1'b0 || b_action_data !== 2'd0 || b_action_explore !== 1'b0) begin
      errors++;
      $display("FAIL b_reset_outputs: valid %0b ready %0b data %0d explore %0b, required all 0",
               b_action_valid, b_reward_ready, b_action_data, b_action_explore);
    end
    qb = '{127, 127, 127, 127};
    sb_b.delete();
    b_reset = 1'b0;
    repeat (4) @(negedge clock);
    b_predict();
    for (int n = 0; n < 200; n++) begin
      b_take_action(cur_b, ex);
      old = qb[cur_b];
      b_give_reward(-128, cur_b);
      v = $signed(dut_b.table_q[cur_b]);
      checks++;
      if (v !== qb[cur_b]) begin errors++; $display("FAIL sat_value n%0d: got %0d, required %0d", n, v, qb[cur_b]); end
      checks++;
      if (v > old) begin errors++; $display("FAIL sat_monotonic n%0d: got %0d, required <= %0d", n, v, old); end
    end
  endtask

  task automatic test_explore();
    int ex, n_exp, r, v;
    n_exp = 0;
    for (int n = 0; n < 4000; n++) begin
      b_take_action(cur_b, ex);
      n_exp += ex;
      r = int'($urandom_range(0, 255)) - 128;
      b_give_reward(r, cur_b);
    end
    checks++;
    if (n_exp * 100 < 20 * 4000 || n_exp * 100 > 30 * 4000) begin
      errors++;
      $display("FAIL explore_fraction: got %0d of 4000, required 800..1200", n_exp);
    end
    for (int j = 0; j < 4; j++) begin
      v = $signed(dut_b.table_q[j]);
      checks++;
      if (v !== qb[j]) begin errors++; $display("FAIL explore_final_q%0d: got %0d, required %0d", j, v, qb[j]); end
    end
  endtask

  initial begin
    test_reset();
    test_learning();
    test_backpressure();
    test_reset_mid_scan();
    test_saturation();
    test_explore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running after 90000 cycles, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
